// File: rtl/shift_sequencer_if.sv
// Request/response bus of the shift sequencer; result and flags are
// tri-stated by the sequencer when oe is low.
interface shift_sequencer_if #(
  parameter int WIDTH       = 8,
  parameter int SHAMT_WIDTH = 3
);
  logic                   start;
  logic                   right_left;
  logic                   arith;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [WIDTH-1:0]       operand;
  logic                   oe;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       result;
  logic [2:0]             flags;

  modport master (
    output start, right_left, arith, shamt, operand, oe,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, right_left, arith, shamt, operand, oe,
    output busy, done, result, flags
  );
endinterface

// File: rtl/shift_sequencer.sv
// Bit-serial shifter: one single-bit shift per clock, result and
// zero/negative/carry flags registered on completion.
module shift_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SHAMT_WIDTH = 3
) (
  input  logic clock,
  input  logic nreset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       work_q, work_d;
  logic                   dir_q, dir_d;
  logic                   ar_q, ar_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [2:0]             flags_q, flags_d;
  logic [WIDTH-1:0]       sh;
  logic                   sh_out;

  // One-bit step of the captured word; sh_out is the bit falling off the end
  always_comb begin
    if (dir_q) begin
      sh     = {(ar_q & work_q[WIDTH-1]), work_q[WIDTH-1:1]};
      sh_out = work_q[0];
    end else begin
      sh     = {work_q[WIDTH-2:0], 1'b0};
      sh_out = work_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dir_d    = dir_q;
    ar_d     = ar_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          work_d = bus.operand;
          dir_d  = bus.right_left;
          ar_d   = bus.arith;
          cnt_d  = bus.shamt;
          if (bus.shamt == '0) begin
            state_d  = DONE;
            result_d = bus.operand;
            flags_d  = {1'b0, bus.operand[WIDTH-1], (bus.operand == '0)};
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = sh;
        cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        // The edge performing the final shift also publishes the result
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          state_d  = DONE;
          result_d = sh;
          flags_d  = {sh_out, sh[WIDTH-1], (sh == '0)};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dir_q    <= 1'b0;
      ar_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dir_q    <= dir_d;
      ar_q     <= ar_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.result = bus.oe ? result_q : {WIDTH{1'bz}};
  assign bus.flags  = bus.oe ? flags_q  : 3'bzzz;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expectations.
module tb_shift_sequencer;
  logic clock = 1'b0;
  logic nreset;
  int   vectors = 0;
  int   miscompares = 0;

  shift_sequencer_if #(.WIDTH(8), .SHAMT_WIDTH(3)) sif ();

  shift_sequencer #(.WIDTH(8), .SHAMT_WIDTH(3)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (sif.slave)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic launch(input logic [7:0] op, input logic [2:0] sa, input logic rl, input logic ar);
    sif.operand    = op;
    sif.shamt      = sa;
    sif.right_left = rl;
    sif.arith      = ar;
    sif.start      = 1'b1;
    tick();
    sif.start      = 1'b0;
    sif.operand    = 8'h5A;
    sif.shamt      = 3'd5;
    sif.right_left = ~rl;
    sif.arith      = ~ar;
  endtask

  task automatic test_reset;
    sif.oe = 1'b1;
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("reset_result", sif.result, 8'h00);
    chk("reset_flags", {5'b0, sif.flags}, 8'h00);
    chk("reset_busy", {7'b0, sif.busy}, 8'h00);
    chk("reset_done", {7'b0, sif.done}, 8'h00);
    sif.oe = 1'b0;
    #1;
    chk("hiz_result", sif.result, 8'hzz);
    chk("hiz_flags", {5'b0, sif.flags}, {5'b0, 3'bzzz});
    sif.oe = 1'b1;
  endtask

  task automatic test_left;
    launch(8'h81, 3'd1, 1'b0, 1'b0);
    chk("left_busy", {7'b0, sif.busy}, 8'h01);
    chk("left_nodone", {7'b0, sif.done}, 8'h00);
    tick();
    chk("left_done", {7'b0, sif.done}, 8'h01);
    chk("left_busy_off", {7'b0, sif.busy}, 8'h00);
    chk("left_result", sif.result, 8'h02);
    chk("left_flags", {5'b0, sif.flags}, 8'h04);
    tick();
    chk("left_done_1cyc", {7'b0, sif.done}, 8'h00);
  endtask

  task automatic test_right_logical;
    // oe low during the run: sequencing must not depend on it
    sif.oe = 1'b0;
    launch(8'h80, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("rl_busy", {7'b0, sif.busy}, 8'h01);
      chk("rl_nodone", {7'b0, sif.done}, 8'h00);
      if (i == 3) begin
        sif.oe = 1'b1;
        #1;
        chk("rl_result_held", sif.result, 8'h02);
        sif.oe = 1'b0;
      end
      tick();
    end
    sif.oe = 1'b1;
    #1;
    chk("rl_done", {7'b0, sif.done}, 8'h01);
    chk("rl_result", sif.result, 8'h01);
    chk("rl_flags", {5'b0, sif.flags}, 8'h00);
    tick();
  endtask

  task automatic test_right_arith;
    launch(8'h80, 3'd3, 1'b1, 1'b1);
    tick(); tick();
    chk("ra_busy", {7'b0, sif.busy}, 8'h01);
    tick();
    chk("ra_done", {7'b0, sif.done}, 8'h01);
    chk("ra_result", sif.result, 8'hF0);
    chk("ra_flags", {5'b0, sif.flags}, 8'h02);
    tick();
    launch(8'h00, 3'd0, 1'b1, 1'b1);
    chk("zero_done", {7'b0, sif.done}, 8'h01);
    chk("zero_busy", {7'b0, sif.busy}, 8'h00);
    chk("zero_result", sif.result, 8'h00);
    chk("zero_flags", {5'b0, sif.flags}, 8'h01);
    tick();
    chk("zero_idle", {7'b0, sif.done}, 8'h00);
  endtask

  task automatic test_abort;
    launch(8'hFF, 3'd7, 1'b0, 1'b0);
    sif.operand = 8'h01;
    sif.shamt   = 3'd0;
    sif.start   = 1'b1;
    tick();
    sif.start   = 1'b0;
    chk("abort_ignored_busy", {7'b0, sif.busy}, 8'h01);
    chk("abort_ignored_done", {7'b0, sif.done}, 8'h00);
    tick(); tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("abort_busy", {7'b0, sif.busy}, 8'h00);
    chk("abort_done", {7'b0, sif.done}, 8'h00);
    chk("abort_result", sif.result, 8'h00);
    chk("abort_flags", {5'b0, sif.flags}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", {7'b0, sif.done | sif.busy}, 8'h00);
    end
  endtask

  task automatic test_back_to_back;
    launch(8'h0F, 3'd2, 1'b0, 1'b0);
    tick(); tick();
    chk("b2b_first_done", {7'b0, sif.done}, 8'h01);
    chk("b2b_first_result", sif.result, 8'h3C);
    chk("b2b_first_flags", {5'b0, sif.flags}, 8'h00);
    launch(8'h01, 3'd1, 1'b1, 1'b0);
    chk("b2b_no_idle", {7'b0, sif.busy}, 8'h01);
    chk("b2b_held", sif.result, 8'h3C);
    tick();
    chk("b2b_second_done", {7'b0, sif.done}, 8'h01);
    chk("b2b_second_result", sif.result, 8'h00);
    chk("b2b_second_flags", {5'b0, sif.flags}, 8'h05);
    tick();
  endtask

  initial begin
    sif.start      = 1'b0;
    sif.right_left = 1'b0;
    sif.arith      = 1'b0;
    sif.shamt      = 3'd0;
    sif.operand    = 8'h00;
    sif.oe         = 1'b1;
    nreset         = 1'b0;
    tick();
    test_reset();
    test_left();
    test_right_logical();
    test_right_arith();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width; only 8 is supported.
REQ-002 SHALL provide parameter SHAMT_WIDTH, default 3, shift-amount width; 2**SHAMT_WIDTH SHALL equal WIDTH.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request a new shift operation.
REQ-006 SHALL have port right_left  input  1  1 = shift right, 0 = shift left.
REQ-007 SHALL have port arith  input  1  1 = arithmetic right shift (sign fill); ignored for left shifts.
REQ-008 SHALL have port shamt  input  3  shift amount, 0..7.
REQ-009 SHALL have port operand  input  8  value to shift.
REQ-010 SHALL have port oe  input  1  output enable for result and flags bus drivers.
REQ-011 SHALL have port busy  output  1  high while shifting.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port result  output  8  shifted value; high-Z when oe=0.
REQ-014 SHALL have port flags  output  3  bit0 zero, bit1 negative, bit2 carry; high-Z when oe=0.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; busy=1 only in SHIFT, done=1 only in DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in SHIFT SHALL be ignored with no side effects.
REQ-017 On accepting edge k, SHALL capture operand, right_left, arith, and shamt into internal registers; later input changes SHALL NOT affect the operation.
REQ-018 On acceptance, SHALL go to SHIFT if shamt>0, else to DONE with carry cleared.
REQ-019 In SHIFT, SHALL perform exactly one single-bit shift per edge and decrement the remaining count; the edge that performs the last shift SHALL move to DONE.
REQ-020 Left shift: zero fill at bit0, carry = bit7 shifted out.
REQ-021 Right logical shift: zero fill at bit7; right arithmetic shift: bit7 preserved. Carry for both = bit0 shifted out.
REQ-022 Carry SHALL equal the last bit shifted out, and 0 for shamt=0.
REQ-023 The cycle after edge k+shamt SHALL have done=1, which is the same as the cycle after edge k when shamt=0.
REQ-024 On entering DONE, SHALL load the result and flags registers: zero = (result==0), negative = result[7], carry per REQ-022.
REQ-025 Result and flags registers SHALL hold their value until the next DONE entry or reset; they SHALL NOT change during SHIFT.
REQ-026 DONE SHALL last exactly one cycle, then go to IDLE, or go to SHIFT/DONE if start is accepted in that cycle (back-to-back).
REQ-027 oe SHALL affect only the output drivers; sequencing SHALL proceed regardless of oe.

Reset
REQ-028 With nreset=0 at an edge: state=IDLE, count=0, working/result/flags registers=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start and abort any in-progress operation with no done pulse.
REQ-030 After reset with oe=1: result=8'h00 and flags=3'b000, since flags are registered and not recomputed from reset value.

Verification
REQ-031 Reset: nreset=0 one cycle, oe=1 -> result=00, flags=000, busy=0, done=0; then oe=0 -> result/flags all Z.
REQ-032 Left shift: operand=0x81, shamt=1, right_left=0 -> busy for 1 cycle, done one cycle later, result=0x02, flags=100 (C=1, N=0, Z=0).
REQ-033 Right logical shift: operand=0x80, shamt=7, right_left=1, arith=0 -> busy for 7 cycles, done one cycle after edge k+7, result=0x01, flags=000.
REQ-034 Right arithmetic shift: operand=0x80, shamt=3, arith=1 -> result=0xF0, flags=010; next case shamt=0, operand=0x00 -> done in the cycle after the start edge, result=0x00, flags=001.
REQ-035 Abort and ignore: start with 0xFF, shamt=7 left; pulse start again during SHIFT -> ignored. Assert nreset=0 after 3 shifts -> busy=0, no done, result=00.
REQ-036 Back-to-back: assert start in the DONE cycle with new operands -> second operation accepted with no IDLE cycle, and the first result held until the second done.
